matrix_scan_ctrl: RTL and testbench

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

---
 rtl/matrix_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: 6x6 LED matrix row scanner with a double-buffered frame store.
// Each row is preceded by a blanking interval, then driven for a dwell period.
// A new frame handed over via fb_valid/fb_ready waits in a pending buffer and
// becomes visible only at the frame boundary (last drive cycle of row 5).
module matrix_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 2000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [35:0] fb_data,
  input  logic        fb_valid,
  output logic        fb_ready,
  output logic [5:0]  row,
  output logic [5:0]  col,
  output logic        frame_done
);

  localparam int unsigned MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    LAST_ROW   = 3'd5;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [35:0]   active_q, active_d;
  logic [35:0]   pending_q, pending_d;
  logic          pfull_q, pfull_d;
  logic [5:0]    row_q, row_d;
  logic [5:0]    col_q, col_d;
  logic          fdone_q, fdone_d;

  logic          boundary;
  logic          xfer;

  assign fb_ready   = ~pfull_q;
  assign row        = row_q;
  assign col        = col_q;
  assign frame_done = fdone_q;

  assign xfer = fb_valid & ~pfull_q;

  // Scan sequencer: BLANK -> DRIVE per row, advancing the row index on DRIVE exit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!en) begin
      state_d = ST_BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == LAST_ROW) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Frame buffers: accept into pending when free, promote to active at the frame boundary.
  // A swap needs pfull_q=1 and a transfer needs pfull_q=0, so the two never collide.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pfull_d   = pfull_q;
    if (boundary && pfull_q) begin
      active_d = pending_q;
      pfull_d  = 1'b0;
    end
    if (xfer) begin
      pending_d = fb_data;
      pfull_d   = 1'b1;
    end
  end

  // Output decode from next state so the registered outputs line up with the state registers.
  always_comb begin
    row_d   = '0;
    col_d   = '1;
    fdone_d = boundary;
    if (state_d == ST_DRIVE) begin
      row_d = 6'd1 << idx_d;
      unique case (idx_d)
        3'd0:    col_d = ~active_d[5:0];
        3'd1:    col_d = ~active_d[11:6];
        3'd2:    col_d = ~active_d[17:12];
        3'd3:    col_d = ~active_d[23:18];
        3'd4:    col_d = ~active_d[29:24];
        3'd5:    col_d = ~active_d[35:30];
        default: begin
          row_d = '0;
          col_d = '1;
        end
      endcase
    end
  end

  // State, buffer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pfull_q   <= 1'b0;
      row_q     <= '0;
      col_q     <= '1;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pfull_q   <= pfull_d;
      row_q     <= row_d;
      col_q     <= col_d;
      fdone_q   <= fdone_d;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: a time-based reference model predicts
// the outputs after every clock edge; a monitor compares them after the edge.
module tb_matrix_scan_ctrl;

  localparam int DW = 4;
  localparam int BL = 2;
  localparam int P  = DW + BL;
  localparam int F  = 6 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [35:0] fb_data = '0;
  logic        fb_valid = 1'b0;
  logic        fb_ready;
  logic [5:0]  row;
  logic [5:0]  col;
  logic        frame_done;

  matrix_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fb_data(fb_data), .fb_valid(fb_valid),
    .fb_ready(fb_ready), .row(row), .col(col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] row;
    logic [5:0] col;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   started  = 0;

  // Reference model: scan position as elapsed cycles within a frame
  int          m_t = 0;
  logic [35:0] m_active = '0;
  logic [35:0] m_pending = '0;
  bit          m_full = 0;

  // One clock of stimulus; model predicts the outputs that follow the next edge.
  task automatic cyc(input bit r, input bit e, input bit v, input logic [35:0] d);
    exp_t x;
    bit   bnd;
    bit   xf;
    int   rr;
    @(negedge clk);
    rst_n = r; en = e; fb_valid = v; fb_data = d;
    bnd = 0;
    if (!r) begin
      m_t = 0; m_active = '0; m_pending = '0; m_full = 0;
    end else begin
      xf = v && !m_full;
      if (!e) begin
        m_t = 0;
      end else begin
        bnd = (m_t == F - 1);
        m_t = (m_t + 1) % F;
        if (bnd && m_full) begin
          m_active = m_pending;
          m_full   = 0;
        end
      end
      if (xf) begin
        m_pending = d;
        m_full    = 1;
      end
    end
    rr = m_t / P;
    if (r && e && (m_t % P) >= BL) begin
      x.row = 6'd1 << rr;
      x.col = ~m_active[rr*6 +: 6];
    end else begin
      x.row = 6'd0;
      x.col = 6'h3F;
    end
    x.fd  = bnd;
    x.rdy = !m_full;
    exp_q.push_back(x);
    started = 1;
  endtask

  // Monitor: compares DUT outputs after every edge against the queued prediction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_underflow: no prediction for observed row=%b col=%b fd=%b rdy=%b",
                   row, col, frame_done, fb_ready);
        end else begin
          x = exp_q.pop_front();
          if (row === x.row && col === x.col && frame_done === x.fd && fb_ready === x.rdy)
            n_pass++;
          else
            $display("FAIL outputs @%0t: got row=%b col=%b fd=%b rdy=%b, expected row=%b col=%b fd=%b rdy=%b",
                     $time, row, col, frame_done, fb_ready, x.row, x.col, x.fd, x.rdy);
        end
      end
    end
  end

  task automatic bounded_fail(input string name);
    n_checks++;
    $display("FAIL %s: condition not reached within cycle budget (got none, required reached)", name);
  endtask

  initial begin
    logic [63:0] rnd;
    bit          e_r;
    int          k;

    // Reset, then plain scanning with no frames
    repeat (3) cyc(0, 1, 0, '0);
    repeat (2 * F + 5) cyc(1, 1, 0, '0);

    // Single pixel r0,c0 frame
    cyc(1, 1, 1, 36'h000000001);
    repeat (2 * F) cyc(1, 1, 0, '0);

    // Back-to-back frames A then B with fb_valid held
    for (k = 0; k < 3 * F; k++) cyc(1, 1, 1, (k < 5) ? 36'hAAAAAAAAA : 36'h555555555);
    repeat (F) cyc(1, 1, 0, '0);

    // Transfer coinciding with the frame boundary
    for (k = 0; k < 2 * F && !(m_t == F - 1 && !m_full); k++) cyc(1, 1, 0, '0);
    if (!(m_t == F - 1 && !m_full)) bounded_fail("boundary_align");
    cyc(1, 1, 1, 36'hFC0FC0FC0);
    repeat (2 * F + 2) cyc(1, 1, 0, '0);

    // Drop en mid-DRIVE of row 3 for 10 cycles
    for (k = 0; k < 2 * F && !(m_t / P == 3 && m_t % P >= BL + 1); k++) cyc(1, 1, 0, '0);
    if (!(m_t / P == 3 && m_t % P >= BL + 1)) bounded_fail("row3_drive_align");
    repeat (10) cyc(1, 0, 0, '0);
    repeat (F + 4) cyc(1, 1, 0, '0);

    // Reset mid-DRIVE with active nonzero and pending full
    cyc(1, 1, 1, 36'hFFFFFFFFF);
    repeat (F + 2) cyc(1, 1, 0, '0);
    cyc(1, 1, 1, 36'h123456789);
    for (k = 0; k < 2 * F && !(m_t % P >= BL + 1); k++) cyc(1, 1, 0, '0);
    cyc(0, 1, 0, '0);
    repeat (F + 4) cyc(1, 1, 0, '0);

    // Randomised traffic with enable toggles and occasional resets
    e_r = 1;
    for (int i = 0; i < 1500; i++) begin
      if (e_r ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 20)) e_r = ~e_r;
      rnd = {$urandom, $urandom};
      cyc(($urandom_range(0, 299) != 0), e_r, ($urandom_range(0, 3) == 0), rnd[35:0]);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d predictions left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
